// File: rtl/rssb_datapath_if.sv
// rtl/rssb_datapath_if.sv - control/status bundle between the RSSB control unit and its datapath
//
// Purpose: carries the datapath control strobes, the program-load port and
// the datapath status outputs as a single connection.
// Ports:
//   control    : sel_mem, sel_pc, write_op1, write_acc, write_mem, write_pc
//   loader     : prog_we, prog_addr[ADDR_W], prog_wdata[DATA_W]
//   status     : neg, pc_o[ADDR_W], acc_o[DATA_W], op1_o[DATA_W]
// Modports: master = control unit / loader side, slave = datapath side.
interface rssb_datapath_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              sel_mem;
    logic              sel_pc;
    logic              write_op1;
    logic              write_acc;
    logic              write_mem;
    logic              write_pc;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_wdata;
    logic              neg;
    logic [ADDR_W-1:0] pc_o;
    logic [DATA_W-1:0] acc_o;
    logic [DATA_W-1:0] op1_o;

    modport master (
        output sel_mem, sel_pc, write_op1, write_acc, write_mem, write_pc,
        output prog_we, prog_addr, prog_wdata,
        input  neg, pc_o, acc_o, op1_o
    );

    modport slave (
        input  sel_mem, sel_pc, write_op1, write_acc, write_mem, write_pc,
        input  prog_we, prog_addr, prog_wdata,
        output neg, pc_o, acc_o, op1_o
    );
endinterface

// File: rtl/rssb_datapath.sv
// rtl/rssb_datapath.sv - RSSB (reverse-subtract-and-skip-if-borrow) datapath
//
// Purpose: word memory with combinational read, accumulator, op1 register and
// PC. diff = mem_rdata - acc drives the accumulator and the memory write port;
// neg is the borrow/sign of diff for the control unit.
// Ports:
//   clk : single clock, rising edge
//   rst : synchronous active-high reset; also the program-load window
//   dp  : rssb_datapath_if.slave (control strobes, loader port, status)
// Configuration:
//   RSSB_NEG_REG_EN : when defined, neg is a flop loaded on write_acc edges;
//                     otherwise neg is combinational from diff.
module rssb_datapath #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    rssb_datapath_if.slave dp
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] pc_q,  pc_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] op1_q, op1_d;

    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] diff;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    always_comb begin
        rd_addr   = dp.sel_mem ? op1_q[ADDR_W-1:0] : pc_q;
        mem_rdata = mem[rd_addr];
        diff      = mem_rdata - acc_q;

        pc_d  = pc_q;
        acc_d = acc_q;
        op1_d = op1_q;
        if (dp.write_pc) begin
            pc_d = pc_q + (dp.sel_pc ? ADDR_W'(2) : ADDR_W'(1));
        end
        if (dp.write_acc) begin
            acc_d = diff;
        end
        if (dp.write_op1) begin
            op1_d = mem_rdata;
        end

        // One memory write port shared in time: the loader owns it while rst
        // is high, the datapath owns it otherwise, so the two never collide.
        if (rst) begin
            wr_en   = dp.prog_we;
            wr_addr = dp.prog_addr;
            wr_data = dp.prog_wdata;
        end else begin
            wr_en   = dp.write_mem;
            wr_addr = op1_q[ADDR_W-1:0];
            wr_data = diff;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= '0;
            acc_q <= '0;
            op1_q <= '0;
        end else begin
            pc_q  <= pc_d;
            acc_q <= acc_d;
            op1_q <= op1_d;
        end
    end

    // Memory contents survive reset so a program loaded during rst persists.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

`ifdef RSSB_NEG_REG_EN
    logic neg_q, neg_d;

    always_comb begin
        neg_d = neg_q;
        if (dp.write_acc) begin
            neg_d = diff[DATA_W-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= neg_d;
        end
    end

    assign dp.neg = neg_q;
`else
    assign dp.neg = diff[DATA_W-1];
`endif

    assign dp.pc_o  = pc_q;
    assign dp.acc_o = acc_q;
    assign dp.op1_o = op1_q;
endmodule

// File: tb/tb_rssb_datapath.sv
// tb/tb_rssb_datapath.sv - self-checking bench for rssb_datapath
module tb_rssb_datapath;
    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int DEPTH = 256;
    localparam int WMOD  = 65536;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rssb_datapath_if #(.DATA_W(DW), .ADDR_W(AW)) dp_if();

    rssb_datapath #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .dp  (dp_if)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Behavioural model: plain integers, memory as an int array.
    int m_mem [DEPTH];
    int m_pc   = 0;
    int m_acc  = 0;
    int m_op1  = 0;
    int m_negr = 0;

    function automatic int pattern(int i);
        case (i)
            0:       return 16'h0010;
            1:       return 16'h0003;
            2:       return 16'h0007;
            16'h10:  return 16'h0005;
            16'h20:  return 16'h0001;
            default: return (i * 16'h9E37 + 16'h0055) % WMOD;
        endcase
    endfunction

    function automatic int m_raddr();
        return dp_if.sel_mem ? (m_op1 % DEPTH) : m_pc;
    endfunction

    function automatic int m_diff();
        return (m_mem[m_raddr()] - m_acc + WMOD) % WMOD;
    endfunction

    always @(posedge clk) begin
        int d, rdat, npc, nacc, nop1;
        d    = m_diff();
        rdat = m_mem[m_raddr()];
        if (rst) begin
            if (dp_if.prog_we) m_mem[int'(dp_if.prog_addr)] = int'(dp_if.prog_wdata);
            m_pc   = 0;
            m_acc  = 0;
            m_op1  = 0;
            m_negr = 0;
        end else begin
            npc  = m_pc;
            nacc = m_acc;
            nop1 = m_op1;
            if (dp_if.write_pc)  npc  = (m_pc + (dp_if.sel_pc ? 2 : 1)) % DEPTH;
            if (dp_if.write_op1) nop1 = rdat;
            if (dp_if.write_acc) begin
                nacc   = d;
                m_negr = (d >= WMOD / 2) ? 1 : 0;
            end
            if (dp_if.write_mem) m_mem[m_op1 % DEPTH] = d;
            m_pc  = npc;
            m_acc = nacc;
            m_op1 = nop1;
        end
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_pc",  int'(dp_if.pc_o),  m_pc);
            chk("model_acc", int'(dp_if.acc_o), m_acc);
            chk("model_op1", int'(dp_if.op1_o), m_op1);
`ifdef RSSB_NEG_REG_EN
            chk("model_neg", int'(dp_if.neg), m_negr);
`else
            chk("model_neg", int'(dp_if.neg), (m_diff() >= WMOD / 2) ? 1 : 0);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_strobes();
        dp_if.sel_mem   = 1'b0;
        dp_if.sel_pc    = 1'b0;
        dp_if.write_op1 = 1'b0;
        dp_if.write_acc = 1'b0;
        dp_if.write_mem = 1'b0;
        dp_if.write_pc  = 1'b0;
        dp_if.prog_we   = 1'b0;
    endtask

    // {sel_mem, sel_pc, write_op1, write_acc, write_mem, write_pc}
    logic [5:0] vec_tbl [8] = '{6'b101111, 6'b000100, 6'b100110, 6'b011001,
                                6'b001111, 6'b100010, 6'b110111, 6'b000110};

    initial begin
        rst              = 1'b1;
        clear_strobes();
        dp_if.prog_addr  = '0;
        dp_if.prog_wdata = '0;

        for (int i = 0; i < DEPTH; i++) begin
            dp_if.prog_we    = 1'b1;
            dp_if.prog_addr  = AW'(i);
            dp_if.prog_wdata = DW'(pattern(i));
            step();
        end
        dp_if.prog_we = 1'b0;
        step();
        chk_en = 1'b1;
        chk("reset_pc",  int'(dp_if.pc_o),  0);
        chk("reset_acc", int'(dp_if.acc_o), 0);
        chk("reset_op1", int'(dp_if.op1_o), 0);
        rst = 1'b0;

        // Fetch op1 from mem[PC=0].
        dp_if.sel_mem = 1'b0; dp_if.write_op1 = 1'b1; step(); clear_strobes();
        chk("fetch_op1", int'(dp_if.op1_o), 16'h0010);

        dp_if.write_pc = 1'b1; step(); clear_strobes();
        chk("pc_inc1", int'(dp_if.pc_o), 1);
        dp_if.write_acc = 1'b1; step(); clear_strobes();
        chk("acc_load3", int'(dp_if.acc_o), 3);

        // acc and mem[0x10] both take 5-3.
        dp_if.sel_mem = 1'b1; dp_if.write_acc = 1'b1; dp_if.write_mem = 1'b1;
        step();
        clear_strobes();
        dp_if.sel_mem = 1'b1;
        #1;
        chk("acc_diff2", int'(dp_if.acc_o), 2);
        chk("neg_zero", int'(dp_if.neg), 0);
        clear_strobes();

        dp_if.write_pc = 1'b1; step(); clear_strobes();
        dp_if.write_acc = 1'b1; step(); clear_strobes();
        chk("acc_load5", int'(dp_if.acc_o), 5);

        // mem[0x10]=2, acc=5 -> diff 0xFFFD.
        dp_if.sel_mem = 1'b1;
        #1;
`ifdef RSSB_NEG_REG_EN
        chk("neg_before_acc", int'(dp_if.neg), 0);
`else
        chk("neg_borrow", int'(dp_if.neg), 1);
`endif
        dp_if.write_acc = 1'b1; step(); dp_if.write_acc = 1'b0;
        #1;
        chk("acc_fffd", int'(dp_if.acc_o), 16'hFFFD);
`ifdef RSSB_NEG_REG_EN
        chk("neg_after_acc", int'(dp_if.neg), 1);
`else
        chk("neg_after_acc", int'(dp_if.neg), 0);
`endif
        clear_strobes();

        // PC wrap: 2 -> 0xFE with skips, then +2 and +1 across the top.
        for (int i = 0; i < 126; i++) begin
            dp_if.write_pc = 1'b1; dp_if.sel_pc = 1'b1; step();
        end
        chk("pc_fe", int'(dp_if.pc_o), 16'h00FE);
        step();
        chk("pc_wrap2", int'(dp_if.pc_o), 0);
        dp_if.sel_pc = 1'b0; step();
        chk("pc_wrap1", int'(dp_if.pc_o), 1);
        for (int i = 0; i < 31; i++) step();
        clear_strobes();
        chk("pc_20", int'(dp_if.pc_o), 16'h0020);

        // Loader write outside reset is ignored.
        dp_if.prog_we = 1'b1; dp_if.prog_addr = 8'h20; dp_if.prog_wdata = 16'h1234;
        step();
        clear_strobes();
        dp_if.write_op1 = 1'b1; step(); clear_strobes();
        chk("prog_ignored", int'(dp_if.op1_o), 1);

        // Reset mid-instruction with every strobe set: nothing is written.
        rst = 1'b1;
        dp_if.sel_mem = 1'b1; dp_if.write_mem = 1'b1; dp_if.write_acc = 1'b1;
        dp_if.write_op1 = 1'b1; dp_if.write_pc = 1'b1;
        step();
        clear_strobes();
        rst = 1'b0;
        chk("midrst_pc",  int'(dp_if.pc_o),  0);
        chk("midrst_acc", int'(dp_if.acc_o), 0);
        chk("midrst_op1", int'(dp_if.op1_o), 0);

        dp_if.write_op1 = 1'b1; step();
        dp_if.sel_mem = 1'b1; step(); clear_strobes();
        chk("mem10_is_2", int'(dp_if.op1_o), 2);
        dp_if.write_pc = 1'b1; step(); clear_strobes();
        dp_if.write_op1 = 1'b1; step(); clear_strobes();
        chk("mem1_kept", int'(dp_if.op1_o), 3);

        // All strobes together use pre-edge values.
        dp_if.sel_mem = 1'b1; dp_if.sel_pc = 1'b1; dp_if.write_op1 = 1'b1;
        dp_if.write_acc = 1'b1; dp_if.write_mem = 1'b1; dp_if.write_pc = 1'b1;
        step();
        clear_strobes();
        chk("simul_op1", int'(dp_if.op1_o), pattern(3));
        chk("simul_acc", int'(dp_if.acc_o), pattern(3));
        chk("simul_pc",  int'(dp_if.pc_o),  3);

        foreach (vec_tbl[k]) begin
            {dp_if.sel_mem, dp_if.sel_pc, dp_if.write_op1,
             dp_if.write_acc, dp_if.write_mem, dp_if.write_pc} = vec_tbl[k];
            step();
        end
        clear_strobes();
        step();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
